// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: MSB-first parallel-in/serial-out with per-bit strobe and busy/done handshake.
// Define SER_PARITY_EN to append an even-parity bit after data bit 0.
module seq_bit_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  output logic             ser_out,
  output logic             bit_stb,
  output logic             busy,
  output logic             done
);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH + 2);
  localparam logic [PW-1:0] PER_LAST = PW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic par_q, par_d;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif
  state_t state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [PW-1:0] per_q, per_d;
  logic [BW-1:0] bit_q, bit_d;
  logic ser_q, ser_d, stb_q, stb_d, busy_q, busy_d, done_q, done_d;
  logic per_end, fin;
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    per_d   = per_q;
    bit_d   = bit_q;
    ser_d   = ser_q;
    stb_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fin     = 1'b0;
`ifdef SER_PARITY_EN
    par_d   = par_q;
`endif
    per_end = per_q == PER_LAST;
    case (state_q)
      IDLE: if (load) begin
        state_d = SHIFT;
        shift_d = data;
        per_d   = '0;
        bit_d   = '0;
        ser_d   = data[WIDTH-1];
        stb_d   = 1'b1;
        busy_d  = 1'b1;
`ifdef SER_PARITY_EN
        par_d   = ^data;
`endif
      end
      SHIFT: if (!per_end) begin
        per_d = per_q + 1'b1;
      end else if (bit_q != BIT_LAST) begin
        shift_d = shift_q << 1;
        ser_d   = shift_q[WIDTH-2];
        bit_d   = bit_q + 1'b1;
        per_d   = '0;
        stb_d   = 1'b1;
      end else begin
`ifdef SER_PARITY_EN
        state_d = PARITY;
        ser_d   = par_q;
        bit_d   = bit_q + 1'b1;
        per_d   = '0;
        stb_d   = 1'b1;
`else
        fin = 1'b1;
`endif
      end
`ifdef SER_PARITY_EN
      PARITY: if (!per_end) per_d = per_q + 1'b1; else fin = 1'b1;
`endif
      default: state_d = IDLE;
    endcase
    // Frame end: one done clk, which doubles as the mandatory idle gap between words.
    if (fin) begin
      state_d = IDLE;
      ser_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      per_d   = '0;
      bit_d   = '0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      per_q   <= '0;
      bit_q   <= '0;
      ser_q   <= 1'b0;
      stb_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      per_q   <= per_d;
      bit_q   <= bit_d;
      ser_q   <= ser_d;
      stb_q   <= stb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
  assign ser_out = ser_q;
  assign bit_stb = stb_q;
  assign busy    = busy_q;
  assign done    = done_q;
endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: random and directed frames on DIV=1 and DIV=4 instances against a frame-timing model.
module tb_seq_bit_serializer;
  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  logic clk = 1'b0, reset = 1'b1, load = 1'b0;
  logic [W-1:0] data = '0;
  logic [1:0] ser, stb, bsy, dn;
  int vec = 0, errs = 0;
  int m_div[2] = '{1, 4};
  bit m_act[2], m_fin[2];
  int m_n[2];
  logic [W-1:0] m_w[2];
  always #5 clk = ~clk;
  seq_bit_serializer #(.WIDTH(W), .DIV(1)) u_d1 (.clk(clk), .reset(reset), .load(load), .data(data),
    .ser_out(ser[0]), .bit_stb(stb[0]), .busy(bsy[0]), .done(dn[0]));
  seq_bit_serializer #(.WIDTH(W), .DIV(4)) u_d4 (.clk(clk), .reset(reset), .load(load), .data(data),
    .ser_out(ser[1]), .bit_stb(stb[1]), .busy(bsy[1]), .done(dn[1]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask
  function automatic logic fbit(input logic [W-1:0] w, input int i);
    return i < W ? w[W-1-i] : logic'(($countones(w) % 2) == 1);
  endfunction
  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0;
      m_fin[i] = 0;
      m_n[i] = 0;
    end
  endtask
  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("div%0d.busy", m_div[i]), 32'(bsy[i]), 32'(m_act[i]));
      chk($sformatf("div%0d.ser_out", m_div[i]), 32'(ser[i]),
          m_act[i] ? 32'(fbit(m_w[i], m_n[i] / m_div[i])) : 32'd0);
      chk($sformatf("div%0d.bit_stb", m_div[i]), 32'(stb[i]),
          32'(m_act[i] && (m_n[i] % m_div[i] == 0)));
      chk($sformatf("div%0d.done", m_div[i]), 32'(dn[i]), 32'(m_fin[i]));
    end
  endtask
  task automatic tick();
    @(posedge clk);
    if (reset) model_clear();
    else for (int i = 0; i < 2; i++) begin
      m_fin[i] = 0;
      if (m_act[i]) begin
        m_n[i]++;
        if (m_n[i] == NB * m_div[i]) begin
          m_act[i] = 0;
          m_fin[i] = 1;
        end
      end else if (load) begin
        m_act[i] = 1;
        m_n[i] = 0;
        m_w[i] = data;
      end
    end
    #1 compare();
  endtask
  task automatic word(input logic [W-1:0] d);
    load = 1'b1;
    data = d;
    tick();
    load = 1'b0;
    data = W'($urandom);
  endtask
  task automatic mid_reset();
    #2 reset = 1'b1;
    #1 model_clear();
    compare();
    tick();
    reset = 1'b0;
  endtask
  initial begin
    model_clear();
    repeat (5) tick();
    reset = 1'b0;
    word(8'h0B);
    repeat (40) tick();
    word(8'hA5);
    repeat (40) tick();
    word(8'h0B);
    repeat (3) tick();
    word(8'hFF);
    repeat (NB - 4) tick();
    word(8'hFF);
    repeat (40) tick();
    word(8'hF0);
    repeat (2) tick();
    mid_reset();
    word(8'h0B);
    repeat (40) tick();
    word(8'hB0);
    repeat (40) tick();
    word(8'h0F);
    repeat (40) tick();
    repeat (2000) begin
      if ($urandom_range(0, 299) == 0) mid_reset();
      else begin
        load = $urandom_range(0, 3) == 0;
        data = W'($urandom);
        tick();
      end
    end
    load = 1'b0;
    repeat (40) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
